// File: rtl/piso_rr_scheduler_if.sv
// Requester handshakes plus serial/status outputs of the round-robin PISO scheduler.
interface piso_rr_scheduler_if #(parameter int WIDTH = 4);
  logic             req0_valid, req1_valid;
  logic [WIDTH-1:0] req0_data, req1_data;
  logic             req0_ready, req1_ready;
  logic             serial_data_out, serial_valid, serial_owner, busy;
  logic [7:0]       grant_count0, grant_count1;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready, serial_data_out, serial_valid, serial_owner, busy,
           grant_count0, grant_count1
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready, serial_data_out, serial_valid, serial_owner, busy,
           grant_count0, grant_count1
  );
endinterface

// File: rtl/piso_rr_scheduler.sv
// Two-requester round-robin arbiter feeding one LSB-first right-shift serializer.
module piso_rr_scheduler #(
  parameter int WIDTH = 4
) (
  input logic clk,
  input logic reset,
  piso_rr_scheduler_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t                 state, state_nxt;
  logic [WIDTH-1:0]       shreg;
  logic [CW-1:0]          cnt;
  logic                   last_grant, owner;
  logic [1:0][7:0]        gcnt;
  logic [1:0]             vld, rdy;
  logic [1:0][WIDTH-1:0]  data;
  logic                   last_bit, open, win, xfer;

  assign vld  = {bus.req1_valid, bus.req0_valid};
  assign data = {bus.req1_data, bus.req0_data};

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign open     = (state == IDLE) || (state == SHIFT && last_bit);
  // On a tie the requester that did not win last time gets the slot.
  assign win      = (vld[0] & vld[1]) ? ~last_grant : vld[1];
  assign xfer     = reset & open & (|vld);
  assign rdy      = {xfer & win, xfer & ~win};

  assign bus.req0_ready   = rdy[0];
  assign bus.req1_ready   = rdy[1];
  assign bus.serial_owner = owner;
  assign bus.grant_count0 = gcnt[0];
  assign bus.grant_count1 = gcnt[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer) state_nxt = SHIFT;
      SHIFT:   if (last_bit && !xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy            = (state == SHIFT);
    bus.serial_valid    = (state == SHIFT);
    bus.serial_data_out = (state == SHIFT) & shreg[0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg      <= '0;
      cnt        <= '0;
      last_grant <= 1'b1;
      owner      <= 1'b0;
    end else if (xfer) begin
      shreg      <= data[win];
      cnt        <= '0;
      last_grant <= win;
      owner      <= win;
    end else if (state == SHIFT) begin
      if (!last_bit) begin
        shreg <= shreg >> 1;
        cnt   <= cnt + 1'b1;
      end else begin
        shreg <= '0;
        cnt   <= '0;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_cnt
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)      gcnt[g] <= '0;
      else if (rdy[g]) gcnt[g] <= gcnt[g] + 8'd1;
    end
  end
endmodule

// File: tb/tb_piso_rr_scheduler.sv
// Directed bench: driver queues expected serial bits, negedge monitor checks them.
module tb_piso_rr_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  typedef struct { logic b; logic own; } exp_t;
  exp_t exp_q[$];

  piso_rr_scheduler_if #(.WIDTH(4)) bus ();
  piso_rr_scheduler #(.WIDTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [3:0] w, input logic own);
    for (int i = 0; i < 4; i++) exp_q.push_back('{b: w[i], own: own});
  endtask

  // Monitor: every valid serial bit must match the next queued expectation.
  always @(negedge clk) begin
    if (reset) begin
      chk("ready_mutex", {31'd0, bus.req0_ready & bus.req1_ready}, 32'd0);
      if (bus.serial_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_bit: got %0b with nothing queued at %0t", bus.serial_data_out, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("serial_bit", {31'd0, bus.serial_data_out}, {31'd0, e.b});
          chk("serial_owner", {31'd0, bus.serial_owner}, {31'd0, e.own});
        end
      end else begin
        chk("idle_data_zero", {31'd0, bus.serial_data_out}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req0_valid = 1'b1; bus.req0_data = 4'h0;
    bus.req1_valid = 1'b0; bus.req1_data = 4'h0;
    #12;
    // Reset state
    chk("rst_ready0", {31'd0, bus.req0_ready}, 32'd0);
    chk("rst_valid", {31'd0, bus.serial_valid}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_owner", {31'd0, bus.serial_owner}, 32'd0);
    chk("rst_gc0", {24'd0, bus.grant_count0}, 32'd0);
    bus.req0_valid = 1'b0;
    @(negedge clk); reset = 1'b1;

    // Tie fairness: req0 first, then alternate with no gap
    @(posedge clk); #1;
    bus.req0_valid = 1'b1; bus.req0_data = 4'hF;
    bus.req1_valid = 1'b1; bus.req1_data = 4'h3;
    push_word(4'hF, 1'b0); push_word(4'h3, 1'b1);
    push_word(4'hF, 1'b0); push_word(4'h3, 1'b1);
    @(negedge clk);
    chk("tie_ready0", {31'd0, bus.req0_ready}, 32'd1);
    chk("tie_ready1", {31'd0, bus.req1_ready}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (i == 8)  bus.req0_valid = 1'b0;
      if (i == 12) bus.req1_valid = 1'b0;
      @(negedge clk);
      chk("tie_valid", {31'd0, bus.serial_valid}, 32'd1);
      if (i == 3) chk("tie_ready1_b3", {31'd0, bus.req1_ready}, 32'd1);
      if (i == 7) chk("tie_ready0_b7", {31'd0, bus.req0_ready}, 32'd1);
      if (i == 4) chk("tie_gc1", {24'd0, bus.grant_count1}, 32'd1);
    end
    chk("tie_gc0", {24'd0, bus.grant_count0}, 32'd2);
    chk("tie_gc1_end", {24'd0, bus.grant_count1}, 32'd2);
    @(posedge clk); @(negedge clk);
    chk("tie_drop", {31'd0, bus.serial_valid}, 32'd0);

    // Single word 1010
    @(posedge clk); #1;
    bus.req0_valid = 1'b1; bus.req0_data = 4'b1010;
    push_word(4'b1010, 1'b0);
    @(negedge clk);
    chk("single_ready0", {31'd0, bus.req0_ready}, 32'd1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    @(negedge clk);
    chk("single_ready_once", {31'd0, bus.req0_ready}, 32'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("single_end_valid", {31'd0, bus.serial_valid}, 32'd0);
    chk("single_end_busy", {31'd0, bus.busy}, 32'd0);
    chk("single_gc0", {24'd0, bus.grant_count0}, 32'd3);

    // Back-to-back on req1: 0110 then 1001
    @(posedge clk); #1;
    bus.req1_valid = 1'b1; bus.req1_data = 4'b0110;
    push_word(4'b0110, 1'b1); push_word(4'b1001, 1'b1);
    @(negedge clk);
    chk("b2b_ready_first", {31'd0, bus.req1_ready}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (i == 0) bus.req1_data = 4'b1001;
      if (i == 4) bus.req1_valid = 1'b0;
      @(negedge clk);
      chk("b2b_valid", {31'd0, bus.serial_valid}, 32'd1);
      if (i < 4) chk("b2b_ready_second", {31'd0, bus.req1_ready}, {31'd0, i == 3});
    end
    @(posedge clk); @(negedge clk);
    chk("b2b_drop", {31'd0, bus.serial_valid}, 32'd0);
    chk("b2b_gc1", {24'd0, bus.grant_count1}, 32'd4);

    // Late request: req1 rises during bit1 of a req0 frame
    @(posedge clk); #1;
    bus.req0_valid = 1'b1; bus.req0_data = 4'b1100;
    push_word(4'b1100, 1'b0); push_word(4'b0101, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (i == 0) bus.req0_valid = 1'b0;
      if (i == 1) begin bus.req1_valid = 1'b1; bus.req1_data = 4'b0101; end
      if (i == 4) bus.req1_valid = 1'b0;
      @(negedge clk);
      chk("late_valid", {31'd0, bus.serial_valid}, 32'd1);
      if (i >= 1 && i < 4) chk("late_ready1", {31'd0, bus.req1_ready}, {31'd0, i == 3});
    end
    @(posedge clk); @(negedge clk);
    chk("late_gc0", {24'd0, bus.grant_count0}, 32'd4);
    chk("late_gc1", {24'd0, bus.grant_count1}, 32'd5);

    // Reset during bit2 of a frame
    @(posedge clk); #1;
    bus.req0_valid = 1'b1; bus.req0_data = 4'b1111;
    push_word(4'b1111, 1'b0);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_valid", {31'd0, bus.serial_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_data", {31'd0, bus.serial_data_out}, 32'd0);
    chk("mid_rst_gc0", {24'd0, bus.grant_count0}, 32'd0);
    chk("mid_rst_gc1", {24'd0, bus.grant_count1}, 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_hold", {31'd0, bus.serial_valid}, 32'd0);
    bus.req0_valid = 1'b1; bus.req0_data = 4'hA;
    bus.req1_valid = 1'b1; bus.req1_data = 4'h5;
    #1;
    chk("rst_forces_ready", {31'd0, bus.req0_ready | bus.req1_ready}, 32'd0);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    chk("post_rst_tie_ready0", {31'd0, bus.req0_ready}, 32'd1);
    push_word(4'hA, 1'b0); push_word(4'h5, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (i == 0) bus.req0_valid = 1'b0;
      if (i == 4) bus.req1_valid = 1'b0;
    end
    @(posedge clk); @(negedge clk);
    chk("post_rst_gc0", {24'd0, bus.grant_count0}, 32'd1);
    chk("post_rst_gc1", {24'd0, bus.grant_count1}, 32'd1);

    // Counter wrap: 256 req0 words after a fresh reset
    #1; reset = 1'b0; #2; reset = 1'b1;
    @(posedge clk); #1;
    bus.req0_valid = 1'b1; bus.req0_data = 4'h0;
    push_word(4'h0, 1'b0);
    for (int n = 0; n < 256; n++) begin
      logic [3:0] w;
      @(posedge clk); #1;
      if (n == 254) chk("wrap_gc0_255", {24'd0, bus.grant_count0}, 32'd255);
      if (n == 255) bus.req0_valid = 1'b0;
      else begin
        w = 4'(n + 1);
        bus.req0_data = w;
        push_word(w, 1'b0);
        repeat (3) @(posedge clk);
      end
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("wrap_gc0", {24'd0, bus.grant_count0}, 32'd0);
    chk("wrap_gc1", {24'd0, bus.grant_count1}, 32'd0);
    chk("wrap_idle", {31'd0, bus.serial_valid}, 32'd0);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
